// File: rtl/mem_store_ctrl.sv
// -----------------------------------------------------------------------------
// mem_store_ctrl
//
// Data-side memory access controller sitting between the EX/MEM pipeline
// boundary and a variable-latency SRAM-like data bus. One load or store is
// accepted at a time. Store data is lane-replicated and byte strobes are
// generated from the access size and address. The bus request/response
// handshake is sequenced by a four-state FSM. The pipeline is held with
// stallreq until the access completes. Loads return the raw 32-bit bus word;
// byte/half extraction is left to the MEM stage.
//
// Parameters
//   TIMEOUT       cycles allowed in REQ+WAIT before the access is aborted
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   req_valid     EX presents a memory access this cycle
//   req_wr        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10/11 word
//   req_addr      byte address
//   req_wdata     right-aligned store data
//   stallreq      pipeline hold request
//   misalign      combinational alignment fault (no bus access is made)
//   resp_valid    one-cycle completion pulse
//   resp_rdata    raw load word; 0 for stores and aborted accesses
//   resp_err      timeout abort flag, qualified by resp_valid
//   data_req      bus request
//   data_wr       bus write
//   data_size     latched access size
//   data_addr     latched byte address
//   data_wstrb    byte strobes (0000 for loads)
//   data_wdata    lane-replicated store data
//   data_addr_ok  bus accepted the request
//   data_data_ok  bus returned read data / write acknowledge
//   data_rdata    bus read data, valid with data_data_ok
// -----------------------------------------------------------------------------
module mem_store_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stallreq,
    output logic        misalign,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    // The timeout counter only ever holds 0 .. TIMEOUT-1: the access leaves
    // REQ/WAIT in the cycle the counter shows TIMEOUT-1.
    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic             r_wr;
    logic [1:0]       r_size;
    logic [31:0]      r_addr;
    logic [3:0]       r_wstrb;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rdata;
    logic             r_err;

    logic w_misaligned;
    logic w_cnt_last;
    logic w_accept;
    logic w_complete;
    logic w_abort;

    // Half needs addr[0]=0, word (size 10 or 11) needs addr[1:0]=00.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lo);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lo[0];
            default: bad = |lo;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] fmt_wstrb(input logic [1:0] size,
                                             input logic [1:0] lo);
        logic [3:0] strb;
        case (size)
            2'b00:   strb = 4'b0001 << lo;
            2'b01:   strb = lo[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Replicate the right-aligned store data across every lane so the bus
    // slave can simply apply the strobes.
    function automatic logic [31:0] fmt_wdata(input logic [1:0]  size,
                                              input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    assign w_misaligned = is_misaligned(req_size, req_addr[1:0]);
    assign w_cnt_last   = (r_cnt == CNT_LAST);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_complete = 1'b0;
        w_abort    = 1'b0;
        stallreq   = 1'b0;
        misalign   = 1'b0;
        data_req   = 1'b0;
        resp_valid = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_misaligned) begin
                        misalign = 1'b1;
                    end else begin
                        // Hold the pipeline in the accept cycle itself so EX
                        // does not advance past the instruction.
                        w_accept = 1'b1;
                        stallreq = 1'b1;
                        w_next   = S_REQ;
                    end
                end
            end

            S_REQ: begin
                stallreq = 1'b1;
                data_req = 1'b1;
                // A bus answer that lands in the final allowed cycle still
                // counts as a normal completion.
                if (data_addr_ok && data_data_ok) begin
                    w_complete = 1'b1;
                    w_next     = S_RESP;
                end else if (w_cnt_last) begin
                    w_abort = 1'b1;
                    w_next  = S_RESP;
                end else if (data_addr_ok) begin
                    w_next = S_WAIT;
                end
            end

            S_WAIT: begin
                stallreq = 1'b1;
                if (data_data_ok) begin
                    w_complete = 1'b1;
                    w_next     = S_RESP;
                end else if (w_cnt_last) begin
                    w_abort = 1'b1;
                    w_next  = S_RESP;
                end
            end

            S_RESP: begin
                // req_valid here is still the instruction just completed.
                resp_valid = 1'b1;
                w_next     = S_IDLE;
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request latch, timeout counter and response capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= 32'h0;
            r_wstrb <= 4'b0000;
            r_wdata <= 32'h0;
            r_cnt   <= '0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr    <= req_wr;
                r_size  <= req_size;
                r_addr  <= req_addr;
                r_wstrb <= req_wr ? fmt_wstrb(req_size, req_addr[1:0]) : 4'b0000;
                r_wdata <= req_wr ? fmt_wdata(req_size, req_wdata) : 32'h0;
                r_cnt   <= '0;
            end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_complete) begin
                r_rdata <= r_wr ? 32'h0 : data_rdata;
                r_err   <= 1'b0;
            end else if (w_abort) begin
                r_rdata <= 32'h0;
                r_err   <= 1'b1;
            end
        end
    end

    assign data_wr    = r_wr;
    assign data_size  = r_size;
    assign data_addr  = r_addr;
    assign data_wstrb = r_wstrb;
    assign data_wdata = r_wdata;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_mem_store_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_store_ctrl
//
// Two controllers share every input: one with a long timeout (16) and one with
// TIMEOUT=4. Each directed access is described by its bus timing (addr_ok
// delay, data_ok delay, optional stray data_ok), from which a timeline model
// derives the expected per-cycle outputs of each instance.
// -----------------------------------------------------------------------------
module tb_mem_store_ctrl;

    localparam int TA    = 16;
    localparam int TB    = 4;
    localparam int NEVER = 1000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    logic        a_stallreq, a_misalign, a_resp_valid, a_resp_err, a_data_req, a_data_wr;
    logic [31:0] a_resp_rdata, a_data_addr, a_data_wdata;
    logic [1:0]  a_data_size;
    logic [3:0]  a_data_wstrb;
    logic        b_stallreq, b_misalign, b_resp_valid, b_resp_err, b_data_req, b_data_wr;
    logic [31:0] b_resp_rdata, b_data_addr, b_data_wdata;
    logic [1:0]  b_data_size;
    logic [3:0]  b_data_wstrb;

    always #5 clk = ~clk;

    mem_store_ctrl #(.TIMEOUT(TA)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .stallreq(a_stallreq), .misalign(a_misalign), .resp_valid(a_resp_valid),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .data_req(a_data_req),
        .data_wr(a_data_wr), .data_size(a_data_size), .data_addr(a_data_addr),
        .data_wstrb(a_data_wstrb), .data_wdata(a_data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    mem_store_ctrl #(.TIMEOUT(TB)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .stallreq(b_stallreq), .misalign(b_misalign), .resp_valid(b_resp_valid),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .data_req(b_data_req),
        .data_wr(b_data_wr), .data_size(b_data_size), .data_addr(b_data_addr),
        .data_wstrb(b_data_wstrb), .data_wdata(b_data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    // Current transaction description
    bit          tr_wr;
    logic [1:0]  tr_size;
    logic [31:0] tr_addr, tr_wdata, tr_rdata;
    int          tr_a, tr_d, tr_stray;
    int          cur_k;
    bit          chk_en = 1'b0;

    int          n_cmp  = 0;
    int          n_fail = 0;

    // Observed response pulses per instance (0 = A, 1 = B)
    int          rv_cnt  [2];
    int          rv_k    [2];
    logic [31:0] rv_data [2];
    logic        rv_err  [2];

    typedef struct {
        bit          stall;
        bit          mis;
        bit          dreq;
        bit          rv;
        bit          rerr;
        logic [31:0] rdata;
    } exp_t;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (k=%0d): got %h, expected %h", name, cur_k, act, req);
        end
    endtask

    // ---------------- model ----------------
    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit m_mis(input logic [1:0] s, input logic [31:0] addr);
        return (int'(addr[1:0]) % nbytes(s)) != 0;
    endfunction

    function automatic logic [3:0] m_wstrb(input bit wr, input logic [1:0] s, input logic [31:0] addr);
        logic [3:0] w;
        int off, nb;
        w   = 4'b0000;
        off = int'(addr[1:0]);
        nb  = nbytes(s);
        if (wr)
            for (int i = 0; i < 4; i++) w[i] = (i >= off) && (i < off + nb);
        return w;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] s, input logic [31:0] wd);
        logic [31:0] r;
        int nb;
        nb = nbytes(s);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic int t_addr();
        return (tr_a < 0) ? NEVER : 1 + tr_a;
    endfunction

    function automatic int t_data();
        return (tr_a < 0 || tr_d < 0) ? NEVER : 1 + tr_a + tr_d;
    endfunction

    // Last cycle the access spends in REQ/WAIT for an instance with timeout T.
    function automatic int t_end(input int T);
        return (t_data() <= T) ? t_data() : T;
    endfunction

    function automatic exp_t m_exp(input int T, input int k);
        exp_t e;
        int te, ta, td;
        e = '{default: 0};
        if (m_mis(tr_size, tr_addr)) begin
            e.mis = (k == 0);
            return e;
        end
        ta      = t_addr();
        td      = t_data();
        te      = t_end(T);
        e.stall = (k <= te);
        e.dreq  = (k >= 1) && (k <= ((ta < te) ? ta : te));
        e.rv    = (k == te + 1);
        e.rerr  = (td > T);
        e.rdata = (e.rerr || tr_wr) ? 32'h0 : tr_rdata;
        return e;
    endfunction

    task automatic check_inst(input int which, input int T,
                              input logic stall, input logic mis, input logic dreq,
                              input logic rv, input logic rerr, input logic [31:0] rdata,
                              input logic dwr, input logic [1:0] dsize, input logic [31:0] daddr,
                              input logic [3:0] dwstrb, input logic [31:0] dwdata);
        exp_t  e;
        string n;
        e = m_exp(T, cur_k);
        n = (which == 0) ? "A" : "B";
        cmp({n, ".stallreq"},   32'(stall), 32'(e.stall));
        cmp({n, ".misalign"},   32'(mis),   32'(e.mis));
        cmp({n, ".data_req"},   32'(dreq),  32'(e.dreq));
        cmp({n, ".resp_valid"}, 32'(rv),    32'(e.rv));
        if (e.rv) begin
            cmp({n, ".resp_err"},   32'(rerr), 32'(e.rerr));
            cmp({n, ".resp_rdata"}, rdata,     e.rdata);
        end
        if (e.dreq) begin
            cmp({n, ".data_wr"},    32'(dwr),    32'(tr_wr));
            cmp({n, ".data_size"},  32'(dsize),  32'(tr_size));
            cmp({n, ".data_addr"},  daddr,       tr_addr);
            cmp({n, ".data_wstrb"}, 32'(dwstrb), 32'(m_wstrb(tr_wr, tr_size, tr_addr)));
            if (tr_wr) cmp({n, ".data_wdata"}, dwdata, m_wdata(tr_size, tr_wdata));
        end
        if (rv === 1'b1) begin
            rv_cnt[which]++;
            rv_k[which]    = cur_k;
            rv_data[which] = rdata;
            rv_err[which]  = rerr;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_inst(0, TA, a_stallreq, a_misalign, a_data_req, a_resp_valid, a_resp_err,
                       a_resp_rdata, a_data_wr, a_data_size, a_data_addr, a_data_wstrb, a_data_wdata);
            check_inst(1, TB, b_stallreq, b_misalign, b_data_req, b_resp_valid, b_resp_err,
                       b_resp_rdata, b_data_wr, b_data_size, b_data_addr, b_data_wstrb, b_data_wdata);
        end
    end

    task automatic check_zero_all(input string tag);
        cmp({tag, " A.stallreq"},   32'(a_stallreq),   0);
        cmp({tag, " A.misalign"},   32'(a_misalign),   0);
        cmp({tag, " A.resp_valid"}, 32'(a_resp_valid), 0);
        cmp({tag, " A.resp_err"},   32'(a_resp_err),   0);
        cmp({tag, " A.resp_rdata"}, a_resp_rdata,      0);
        cmp({tag, " A.data_req"},   32'(a_data_req),   0);
        cmp({tag, " A.data_wr"},    32'(a_data_wr),    0);
        cmp({tag, " A.data_size"},  32'(a_data_size),  0);
        cmp({tag, " A.data_addr"},  a_data_addr,       0);
        cmp({tag, " A.data_wstrb"}, 32'(a_data_wstrb), 0);
        cmp({tag, " A.data_wdata"}, a_data_wdata,      0);
        cmp({tag, " B.stallreq"},   32'(b_stallreq),   0);
        cmp({tag, " B.resp_valid"}, 32'(b_resp_valid), 0);
        cmp({tag, " B.resp_err"},   32'(b_resp_err),   0);
        cmp({tag, " B.data_req"},   32'(b_data_req),   0);
        cmp({tag, " B.data_addr"},  b_data_addr,       0);
    endtask

    // Runs one access from its accept cycle (k=0) until both instances are
    // idle again. Called at posedge+1. abort_k >= 0 pulses rst in that cycle.
    task automatic run_txn(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input int a, input int d,
                           input logic [31:0] rdata, input int stray, input bit hold,
                           input int abort_k);
        bit mis;
        int te_a, kmax;
        tr_wr = wr; tr_size = size; tr_addr = addr; tr_wdata = wdata;
        tr_rdata = rdata; tr_a = a; tr_d = d; tr_stray = stray;
        for (int i = 0; i < 2; i++) begin
            rv_cnt[i] = 0; rv_k[i] = -1; rv_data[i] = 32'h0; rv_err[i] = 1'b0;
        end
        mis  = m_mis(size, addr);
        te_a = t_end(TA);
        kmax = mis ? 1 : (((te_a > t_end(TB)) ? te_a : t_end(TB)) + 2);
        req_wr = wr; req_size = size; req_addr = addr; req_wdata = wdata;
        chk_en = 1'b1;
        for (int k = 0; k <= kmax; k++) begin
            cur_k        = k;
            req_valid    = (k == 0) || (hold && !mis && (k <= te_a + 1));
            data_addr_ok = (k == t_addr());
            data_data_ok = (k == t_data()) || (k == tr_stray);
            data_rdata   = (k == t_data()) ? tr_rdata : (32'hBAD0BAD0 ^ 32'(k));
            if (k == abort_k) begin
                chk_en = 1'b0;
                req_valid = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
                #1 rst = 1'b1;
                #1 check_zero_all("async_rst");
                @(posedge clk); #1;
                check_zero_all("held_rst");
                rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    endtask

    initial begin
        req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_addr = 32'h0; req_wdata = 32'h0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        cur_k = 0;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check_zero_all("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Pin the model's formatting against hand-computed values.
        cmp("model wstrb SB 0x103", 32'(m_wstrb(1'b1, 2'b00, 32'h103)), 32'h8);
        cmp("model wdata SB A5",    m_wdata(2'b00, 32'h000000A5), 32'hA5A5A5A5);
        cmp("model wstrb SH 0x102", 32'(m_wstrb(1'b1, 2'b01, 32'h102)), 32'hC);
        cmp("model wdata SH 1234",  m_wdata(2'b01, 32'h00001234), 32'h12341234);
        cmp("model mis LH 0x201",   32'(m_mis(2'b01, 32'h201)), 32'h1);

        // SW zero-wait
        run_txn(1'b1, 2'b10, 32'h100, 32'hDEADBEEF, 0, 0, 32'h11112222, -1, 1'b1, -1);
        cmp("SW A resp cycle", rv_k[0], 2);
        cmp("SW A resp count", rv_cnt[0], 1);
        cmp("SW A resp_rdata", rv_data[0], 32'h0);

        // SB / SH lane formatting
        run_txn(1'b1, 2'b00, 32'h103, 32'h000000A5, 0, 1, 32'h0, -1, 1'b1, -1);
        run_txn(1'b1, 2'b01, 32'h102, 32'h00001234, 1, 0, 32'h0, -1, 1'b1, -1);

        // LW with addr_ok after 2 cycles, data_ok 3 later
        run_txn(1'b0, 2'b10, 32'h200, 32'h0, 2, 3, 32'h55AA0011, -1, 1'b0, -1);
        cmp("LW A resp_rdata", rv_data[0], 32'h55AA0011);
        cmp("LW A resp count", rv_cnt[0], 1);
        cmp("LW A resp cycle", rv_k[0], 7);

        // LH misaligned
        run_txn(1'b0, 2'b01, 32'h201, 32'h0, -1, -1, 32'h0, -1, 1'b0, -1);
        cmp("LH mis A resp count", rv_cnt[0], 0);

        // Bus never answers; stray data_ok without addr_ok
        run_txn(1'b0, 2'b10, 32'h300, 32'h0, -1, -1, 32'h0, 7, 1'b0, -1);
        cmp("TO B resp cycle", rv_k[1], 5);
        cmp("TO B resp count", rv_cnt[1], 1);
        cmp("TO B resp_err",   32'(rv_err[1]), 1);
        cmp("TO A resp cycle", rv_k[0], 17);

        // Late data_ok after B's timeout
        run_txn(1'b0, 2'b10, 32'h304, 32'h0, 0, 5, 32'hCAFEF00D, -1, 1'b0, -1);
        cmp("late B resp count", rv_cnt[1], 1);
        cmp("late A resp_rdata", rv_data[0], 32'hCAFEF00D);
        cmp("late A resp cycle", rv_k[0], 7);

        // LB, size-11 store, SH low half, misaligned SW
        run_txn(1'b0, 2'b00, 32'h001, 32'h0, 0, 0, 32'h89ABCDEF, -1, 1'b1, -1);
        run_txn(1'b1, 2'b11, 32'h010, 32'h01020304, 0, 2, 32'h0, -1, 1'b1, -1);
        run_txn(1'b1, 2'b01, 32'h100, 32'hFFFF5678, 0, 0, 32'h0, -1, 1'b1, -1);
        run_txn(1'b1, 2'b10, 32'h102, 32'h12345678, -1, -1, 32'h0, -1, 1'b0, -1);

        // Reset during WAIT, then a normal LW
        run_txn(1'b0, 2'b10, 32'h400, 32'h0, 0, -1, 32'h0, -1, 1'b0, 3);
        run_txn(1'b0, 2'b10, 32'h404, 32'h0, 1, 1, 32'h0BADF00D, -1, 1'b1, -1);
        cmp("post-rst A resp_rdata", rv_data[0], 32'h0BADF00D);
        cmp("post-rst A resp cycle", rv_k[0], 4);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
